uart_tx_phy: RTL and testbench
==============================

Name: uart_tx_phy

Overview:
- Transmit path directly downstream of the UART bus FSM.
- Buffers bytes pushed by the FSM's tx_fifo_wr_en strobe in a TX FIFO.
- Serializes each byte onto txd as 8N1 or 8N2 frames, LSB first, at a programmable bit rate.
- Reports FIFO level, full/empty and a watermark flag back to the UART register bank.

Parameters:
- DEPTH, 8, TX FIFO depth in bytes; power of two, minimum 2.
- DIV_WIDTH, 16, width of the bit-rate divisor.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- tx_en  input  1  transmit enable from control register
- nstop  input  1  0 = one stop bit, 1 = two stop bits
- div  input  DIV_WIDTH  bit time is div+1 clocks
- txcnt  input  $clog2(DEPTH)+1  watermark threshold
- tx_fifo_wr_en  input  1  one-cycle push strobe from UART FSM
- tx_fifo_wr_data  input  8  byte to push
- txd  output  1  serial output, idle high, registered
- fifo_full  output  1  count == DEPTH
- fifo_empty  output  1  count == 0
- fifo_count  output  $clog2(DEPTH)+1  bytes held in the FIFO
- txwm  output  1  fifo_count < txcnt
- tx_busy  output  1  state != Idle

Behaviour:
- Reset values:
  - txd=1, fifo_empty=1, fifo_full=0, fifo_count=0, tx_busy=0.
  - txwm=(txcnt>0).
  - State=Idle; pointers, bit counter and divisor counter all 0.
- FIFO:
  - Circular buffer, read and write pointers wrap modulo DEPTH.
  - Push is accepted iff count<DEPTH, or a pop occurs in the same cycle.
  - A push while full with no pop is dropped silently; count and contents are unchanged.
  - Simultaneous push and pop leaves count unchanged, and both pointers advance.
  - fifo_full, fifo_empty and fifo_count are registered and valid the cycle after the edge that changes them.
- States: Idle, Start, Data, Stop.
- Idle:
  - txd=1.
  - If tx_en=1 and FIFO not empty, then on the next edge: pop the head byte into the shift register, latch div into div_q, go to Start.
  - With tx_en=0, bytes stay in the FIFO.
- Start:
  - txd=0 for div_q+1 clocks.
  - Then go to Data with bit index 0.
- Data:
  - txd=shift[0] for div_q+1 clocks per bit, then shift right.
  - After bit index 7 go to Stop, latching stop_cnt = nstop ? 2 : 1.
- Stop:
  - txd=1 for stop_cnt*(div_q+1) clocks, then go to Idle.
  - Idle takes at least one clock before the next Start, so back-to-back frames are separated by one extra high clock.
- Frame length is (10+nstop)*(div_q+1) clocks, plus 1 clock of Idle between frames.
- txd is driven from a flop. It changes on the edge that enters each state or bit, so the first low clock is the cycle after the pop edge.
- Deasserting tx_en mid-frame finishes the current frame; the block then stays in Idle.
- Changing div or nstop mid-frame has no effect until the next frame. nstop is latched on entry to Stop, div at the pop.
- div=0 gives 1 clock per bit.
- Asserting reset mid-frame forces txd=1 and Idle immediately, and empties the FIFO.

Test Plan:
- Single byte: div=3, nstop=0, tx_en=1, push 0xA5.
  - txd low 4 clks.
  - Then bits 1,0,1,0,0,1,0,1 at 4 clks each, then high 4 clks.
  - tx_busy high 40 clks; fifo_count returns to 0 the cycle after the push-pop.
- Two stop bits: div=0, nstop=1, push 0x00.
  - txd = 0 for 9 clks, then 1 for 2 clks.
  - Next frame, if queued, starts low after 1 further idle clk.
- FIFO fill with tx_en=0, DEPTH=8: push 0x01..0x09.
  - fifo_full=1 after 8 pushes, fifo_count=8, 0x09 dropped.
  - Set tx_en=1: bytes 0x01..0x08 emitted in order, then fifo_empty=1.
- Watermark: txcnt=2, push 3 bytes with tx_en=0.
  - txwm goes 1→1→0→0 over the pushes.
  - Enable TX: txwm returns to 1 when count drops to 1.
- Full plus simultaneous pop: FIFO full, tx_en=1, push 0x55 on the exact pop cycle.
  - Push accepted, count stays 8, 0x55 is transmitted last.
- Reset mid-frame: assert reset in Data bit 3.
  - txd=1 and tx_busy=0 immediately, fifo_empty=1.
  - After release with tx_en=1 and no pushes, txd stays 1.

Source files
------------

// File: rtl/uart_tx_phy.sv
// UART transmit path: byte FIFO fed by the bus FSM, serialized onto txd as
// 8N1/8N2 frames (LSB first) at a bit time of div+1 clocks.
module uart_tx_phy #(
  parameter int DEPTH     = 8,
  parameter int DIV_WIDTH = 16,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic                 nstop,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [CW-1:0]        txcnt,
  input  logic                 tx_fifo_wr_en,
  input  logic [7:0]           tx_fifo_wr_data,
  output logic                 txd,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic [CW-1:0]        fifo_count,
  output logic                 txwm,
  output logic                 tx_busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [7:0]           mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [7:0]           shift;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [2:0]           bit_idx;
  logic [1:0]           stop_left;
  logic                 pop;
  logic                 push;
  logic                 bit_done;
  logic [CW-1:0]        count_nxt;

  // Push strobe has no back-pressure: a write is taken when there is room,
  // or when the serializer frees a slot on the same edge; otherwise dropped.
  assign pop      = (state == S_IDLE) && tx_en && !fifo_empty;
  assign push     = tx_fifo_wr_en && (!fifo_full || pop);
  assign bit_done = (div_cnt == div_q);

  always_comb begin
    count_nxt = fifo_count;
    if (push && !pop)      count_nxt = fifo_count + CW'(1);
    else if (pop && !push) count_nxt = fifo_count - CW'(1);
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= tx_fifo_wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_nxt;
      fifo_full  <= (count_nxt == CW'(DEPTH));
      fifo_empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      txd       <= 1'b1;
      shift     <= '0;
      div_q     <= '0;
      div_cnt   <= '0;
      bit_idx   <= '0;
      stop_left <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            div_q   <= div;
            div_cnt <= '0;
            txd     <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            div_cnt <= '0;
            bit_idx <= '0;
            txd     <= shift[0];
            state   <= S_DATA;
          end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
          end
        end
        S_DATA: begin
          if (bit_done) begin
            div_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd       <= 1'b1;
              stop_left <= nstop ? 2'd2 : 2'd1;
              state     <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
            end
          end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
          end
        end
        S_STOP: begin
          if (bit_done) begin
            div_cnt <= '0;
            if (stop_left == 2'd1) state <= S_IDLE;
            else                   stop_left <= stop_left - 2'd1;
          end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign txwm      = (fifo_count < txcnt);
  assign tx_busy   = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_phy.sv
// Directed bench for uart_tx_phy: a frame-level waveform/queue model checked
// every cycle, plus literal expectations for the listed scenarios.
module tb_uart_tx_phy;
  localparam int DEPTH = 8;
  localparam int DW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          tx_en = 1'b0;
  logic          nstop = 1'b0;
  logic [DW-1:0] div = '0;
  logic [CW-1:0] txcnt = '0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          txd, fifo_full, fifo_empty, txwm, tx_busy;
  logic [CW-1:0] fifo_count;
  logic [1:0]    dbg_state;

  always #5 clock = ~clock;

  uart_tx_phy #(.DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .tx_en(tx_en), .nstop(nstop), .div(div),
    .txcnt(txcnt), .tx_fifo_wr_en(wr_en), .tx_fifo_wr_data(wr_data),
    .txd(txd), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .txwm(txwm), .tx_busy(tx_busy),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // exp_q: bytes the FIFO must hold. wave_q: txd levels for coming cycles,
  // 0/1 literal levels, 2 marks entry to the stop period (stop bits are
  // expanded there, using nstop at that moment).
  logic [7:0] exp_q[$];
  logic [1:0] wave_q[$];
  int         m_bt = 1;
  logic       m_txd = 1'b1;
  logic       m_busy = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      wave_q.delete();
      m_txd  = 1'b1;
      m_busy = 1'b0;
    end else begin
      logic       do_pop;
      logic [7:0] head;
      logic [1:0] e;
      do_pop = !m_busy && tx_en && (exp_q.size() > 0);
      if (do_pop) begin
        head = exp_q.pop_front();
        m_bt = int'(div) + 1;
        repeat (m_bt) wave_q.push_back(2'd0);
        for (int i = 0; i < 8; i++)
          repeat (m_bt) wave_q.push_back({1'b0, head[i]});
        wave_q.push_back(2'd2);
      end
      if (wr_en && (exp_q.size() < DEPTH)) exp_q.push_back(wr_data);
      if (wave_q.size() > 0) begin
        e = wave_q.pop_front();
        m_busy = 1'b1;
        if (e == 2'd2) begin
          m_txd = 1'b1;
          repeat ((nstop ? 2 : 1) * m_bt - 1) wave_q.push_back(2'd1);
        end else begin
          m_txd = e[0];
        end
      end else begin
        m_txd  = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clock) begin
    check("txd", txd, m_txd);
    check("tx_busy", tx_busy, m_busy);
    check("fifo_count", fifo_count, exp_q.size());
    check("fifo_full", fifo_full, exp_q.size() == DEPTH);
    check("fifo_empty", fifo_empty, exp_q.size() == 0);
    check("txwm", txwm, exp_q.size() < int'(txcnt));
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered 2 time units after a rising edge.
  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clock);
    #2 wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int  n = 0;
    bit  done = 0;
    while (!done && n < 3000) begin
      @(negedge clock);
      if (fifo_empty && !tx_busy) done = 1;
      n++;
    end
    check("idle_reached", done, 1'b1);
    @(posedge clock);
    #2;
  endtask

  task automatic count_busy(output int n);
    bit done = 0;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clock);
      if (tx_busy) n++;
      else done = 1;
    end
  endtask

  task automatic rx_byte(output logic [7:0] b, output bit ok);
    int n = 0;
    ok = 0;
    b  = '0;
    while (!ok && n < 300) begin
      @(negedge clock);
      if (txd === 1'b0) ok = 1;
      n++;
    end
    if (ok) begin
      repeat (int'(div) + 1) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        b[i] = txd;
        repeat (int'(div) + 1) @(negedge clock);
      end
    end
  endtask

  // ---------------- directed tests ----------------
  logic [7:0]  b;
  bit          ok;
  int          n_busy;
  logic [12:0] got;
  logic [7:0]  exp_bytes [9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55};

  initial begin
    txcnt = 4'd2;
    div   = 16'd3;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // reset state
    check("rst_txd", txd, 1'b1);
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_full", fifo_full, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_txwm_2", txwm, 1'b1);
    txcnt = 4'd0;
    #1 check("rst_txwm_0", txwm, 1'b0);
    txcnt = 4'd2;

    // single byte 0xA5, div=3, 8N1
    tx_en = 1'b1;
    push(8'hA5);
    check("t1_count_after_push", fifo_count, 1);
    @(posedge clock);
    #2;
    check("t1_count_after_pop", fifo_count, 0);
    check("t1_start_low", txd, 1'b0);
    fork
      count_busy(n_busy);
      rx_byte(b, ok);
    join
    check("t1_busy_clks", n_busy, 40);
    check("t1_rx_ok", ok, 1'b1);
    check("t1_rx_byte", b, 8'hA5);
    wait_idle();

    // two stop bits, div=0, two queued 0x00 frames
    div   = 16'd0;
    nstop = 1'b1;
    push(8'h00);
    push(8'h00);
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      got[i] = txd;
    end
    check("t2_wave", got, 13'h0E00);
    wait_idle();
    nstop = 1'b0;

    // watermark, txcnt=2
    tx_en = 1'b0;
    check("t3_wm0", txwm, 1'b1);
    push(8'h11);
    check("t3_wm1", txwm, 1'b1);
    push(8'h22);
    check("t3_wm2", txwm, 1'b0);
    push(8'h33);
    check("t3_wm3", txwm, 1'b0);
    tx_en = 1'b1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      if (fifo_count == 1) ok = 1;
    end
    check("t3_count_reached_1", ok, 1'b1);
    check("t3_wm_back", txwm, 1'b1);
    wait_idle();

    // fill with tx disabled, then push on the pop edge while full
    tx_en = 1'b0;
    for (int i = 1; i <= 9; i++) push(8'(i));
    check("t4_full", fifo_full, 1'b1);
    check("t4_count8", fifo_count, 8);
    tx_en   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h55;
    @(posedge clock);
    #2 wr_en = 1'b0;
    check("t4_pop_push_count", fifo_count, 8);
    check("t4_pop_push_full", fifo_full, 1'b1);
    for (int k = 0; k < 9; k++) begin
      rx_byte(b, ok);
      check("t4_rx_ok", ok, 1'b1);
      check("t4_rx_byte", b, exp_bytes[k]);
    end
    wait_idle();
    check("t4_empty_end", fifo_empty, 1'b1);

    // reset during data bit 3
    div = 16'd3;
    push(8'hA5);
    push(8'h3C);
    repeat (17) @(posedge clock);
    #3;
    check("t5_in_data", dbg_state, 2'd2);
    reset = 1'b1;
    #1;
    check("t5_rst_txd", txd, 1'b1);
    check("t5_rst_busy", tx_busy, 1'b0);
    check("t5_rst_empty", fifo_empty, 1'b1);
    check("t5_rst_count", fifo_count, 0);
    @(posedge clock);
    #2 reset = 1'b0;
    repeat (30) @(posedge clock);
    #2;
    check("t5_txd_idle", txd, 1'b1);
    check("t5_busy_idle", tx_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    checks++;
    errors++;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
